// File: rtl/deser_pkg.sv
// Shared types and sizing helpers for the serial frame deserializer.
package deser_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int          DEF_DATA_W    = 16;
    localparam logic [15:0] DEF_SYNC_WORD = 16'hA5C3;

    // Bits needed to count 0..data_w-1; never narrower than one bit.
    function automatic int bit_cnt_w(input int data_w);
        return (data_w > 2) ? $clog2(data_w) : 1;
    endfunction

    // Bits needed to hold 0..n inclusive.
    function automatic int word_cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/deser_out_reg.sv
// Single-entry valid/ready holding register; a word that arrives while the
// entry is full and not being accepted is dropped and flagged as overflow.
module deser_out_reg
    import deser_pkg::*;
#(
    parameter int W = DEF_DATA_W + 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         clr,
    input  logic         ready,
    output logic [W-1:0] data,
    output logic         valid,
    output logic         overflow
);

    logic drop;

    assign drop = load && valid && !ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data     <= '0;
            valid    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (load && (!valid || ready)) begin
                data  <= load_data;
                valid <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end

            if (drop) begin
                overflow <= 1'b1;
            end else if (clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/serial_frame_deserializer.sv
// Hunts for a sync word on a 1-bit serial link, locks to the frame structure
// and streams out the data words with lock and error status.
module serial_frame_deserializer
    import deser_pkg::*;
#(
    parameter int                DATA_W        = DEF_DATA_W,
    parameter logic [DATA_W-1:0] SYNC_WORD     = DEF_SYNC_WORD,
    parameter int                FRAME_WORDS   = 8,
    parameter int                LOCK_MISS_MAX = 2,
    parameter int                COUNT_W       = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sdata,
    input  logic               bit_en,
    output logic [DATA_W-1:0]  m_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               m_first,
    output logic               locked,
    output logic               lock_lost,
    output logic               overflow,
    input  logic               clr_status,
    output logic [COUNT_W-1:0] frame_cnt,
    output logic [COUNT_W-1:0] sync_err_cnt
);

    localparam int BW = bit_cnt_w(DATA_W);
    localparam int WW = word_cnt_w(FRAME_WORDS);
    localparam int MW = word_cnt_w(LOCK_MISS_MAX);

    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
    localparam logic [WW-1:0] WORD_SYNC = WW'(FRAME_WORDS);
    localparam logic [MW-1:0] MISS_LAST = MW'(LOCK_MISS_MAX - 1);

    state_t            state, state_next;
    logic [DATA_W-1:0] sh, sh_next;
    logic [BW-1:0]     bit_cnt;
    logic [WW-1:0]     word_cnt;
    logic [MW-1:0]     miss_cnt;
    logic              sync_hit, word_done, sync_slot;
    logic              emit, good_sync, bad_sync, drop_lock;
    logic [DATA_W:0]   out_data;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        sh_next    = sh;
        sync_hit   = 1'b0;
        word_done  = 1'b0;
        sync_slot  = 1'b0;
        emit       = 1'b0;
        good_sync  = 1'b0;
        bad_sync   = 1'b0;
        drop_lock  = 1'b0;
        state_next = state;

        if (bit_en) begin
            sh_next = {sh[DATA_W-2:0], sdata};
        end
        sync_hit  = (sh_next == SYNC_WORD);
        word_done = (state == LOCKED) && bit_en && (bit_cnt == BIT_LAST);
        sync_slot = (word_cnt == WORD_SYNC);
        emit      = word_done && !sync_slot;
        good_sync = word_done && sync_slot && sync_hit;
        bad_sync  = word_done && sync_slot && !sync_hit;
        drop_lock = bad_sync && (miss_cnt == MISS_LAST);

        case (state)
            HUNT:    if (bit_en && sync_hit) state_next = LOCKED;
            LOCKED:  if (drop_lock)          state_next = HUNT;
            default: state_next = HUNT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= HUNT;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: only control/status registers need reset for correct behaviour;
    // the shift register is reset too so post-reset hunting starts clean.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh           <= '0;
            bit_cnt      <= '0;
            word_cnt     <= '0;
            miss_cnt     <= '0;
            lock_lost    <= 1'b0;
            frame_cnt    <= '0;
            sync_err_cnt <= '0;
        end else begin
            sh        <= sh_next;
            lock_lost <= drop_lock;

            // Counters idle at zero while hunting, so acquisition needs no reload.
            if (state == HUNT) begin
                bit_cnt  <= '0;
                word_cnt <= '0;
                miss_cnt <= '0;
            end else if (bit_en) begin
                bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
                if (word_done) begin
                    word_cnt <= sync_slot ? '0 : word_cnt + 1'b1;
                end
                if (good_sync) begin
                    miss_cnt <= '0;
                end else if (bad_sync) begin
                    miss_cnt <= drop_lock ? '0 : miss_cnt + 1'b1;
                end
            end

            if (good_sync) begin
                frame_cnt <= frame_cnt + 1'b1;
            end

            // A miss in the same cycle as a clear leaves a count of one.
            if (bad_sync) begin
                if (clr_status) begin
                    sync_err_cnt <= COUNT_W'(1);
                end else if (sync_err_cnt != '1) begin
                    sync_err_cnt <= sync_err_cnt + 1'b1;
                end
            end else if (clr_status) begin
                sync_err_cnt <= '0;
            end
        end
    end

    assign locked = (state == LOCKED);

    deser_out_reg #(.W(DATA_W + 1)) u_out_reg (
        .clk       (clk),
        .reset     (reset),
        .load      (emit),
        .load_data ({sh_next, (word_cnt == '0)}),
        .clr       (clr_status),
        .ready     (m_ready),
        .data      (out_data),
        .valid     (m_valid),
        .overflow  (overflow)
    );

    assign m_data  = out_data[DATA_W:1];
    assign m_first = out_data[0];

endmodule
